// File: rtl/regfile_wb_arb_if.sv
// ============================================================================
// Module   : regfile_wb_arb_if
// Brief    : Writeback request/grant bundle and regfile write port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_wb_arb_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int NREQ  = 3
);
   localparam int ADDR = $clog2(DEPTH);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*ADDR-1:0]  req_reg;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  wr_hold;
   logic                  wr_enable;
   logic [ADDR-1:0]       wr_reg;
   logic [WIDTH-1:0]      wr_data;
   logic [15:0]           wr_count;

   modport master (
      output req_valid, req_reg, req_data, wr_hold,
      input  req_ready, wr_enable, wr_reg, wr_data, wr_count
   );

   modport slave (
      input  req_valid, req_reg, req_data, wr_hold,
      output req_ready, wr_enable, wr_reg, wr_data, wr_count
   );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_arb.sv
// ============================================================================
// Module   : regfile_wb_arb
// Brief    : Round-robin writeback arbiter feeding one regfile write port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arb #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int NREQ  = 3
) (
   input  wire logic       clk,
   input  wire logic       reset_n,
   regfile_wb_arb_if.slave bus
);
   localparam int          ADDR      = $clog2(DEPTH);
   localparam int          PW        = $clog2(NREQ);
   localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

   logic [PW-1:0]    r_rr_ptr;
   logic             r_wr_enable;
   logic [ADDR-1:0]  r_wr_reg;
   logic [WIDTH-1:0] r_wr_data;
   logic [15:0]      r_wr_count;

   logic             w_found;
   logic [PW-1:0]    w_gnt_idx;
   logic             w_xfer;
   logic [NREQ-1:0]  w_ready;
   logic [ADDR-1:0]  w_sel_reg;
   logic [WIDTH-1:0] w_sel_data;

   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NREQ) s = s - NREQ;
      return s[PW-1:0];
   endfunction

   // Scan from the highest offset down so the nearest valid requester wins.
   always_comb begin
      w_found   = 1'b0;
      w_gnt_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (bus.req_valid[wrap_add(r_rr_ptr, k)]) begin
            w_found   = 1'b1;
            w_gnt_idx = wrap_add(r_rr_ptr, k);
         end
      end
   end

   always_comb begin
      w_xfer     = w_found & ~bus.wr_hold & reset_n;
      w_ready    = '0;
      if (w_xfer) w_ready[w_gnt_idx] = 1'b1;
      w_sel_reg  = bus.req_reg[w_gnt_idx*ADDR +: ADDR];
      w_sel_data = bus.req_data[w_gnt_idx*WIDTH +: WIDTH];
   end

   // Writes to register 0 are accepted but never reach the regfile.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rr_ptr    <= '0;
         r_wr_enable <= 1'b0;
         r_wr_reg    <= '0;
         r_wr_data   <= '0;
         r_wr_count  <= '0;
      end else begin
         r_wr_enable <= 1'b0;
         if (w_xfer) begin
            r_rr_ptr <= wrap_add(w_gnt_idx, 1);
            if (w_sel_reg != '0) begin
               r_wr_enable <= 1'b1;
               r_wr_reg    <= w_sel_reg;
               r_wr_data   <= w_sel_data;
               if (r_wr_count != C_CNT_MAX) r_wr_count <= r_wr_count + 16'd1;
            end
         end
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.wr_enable = r_wr_enable;
   assign bus.wr_reg    = r_wr_reg;
   assign bus.wr_data   = r_wr_data;
   assign bus.wr_count  = r_wr_count;
endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arb.sv
// ============================================================================
// Module   : tb_regfile_wb_arb
// Brief    : Directed plus randomized bench for regfile_wb_arb with a reference model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arb;
   localparam int W = 32;
   localparam int D = 32;
   localparam int N = 3;
   localparam int A = $clog2(D);

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   // Reference model state: what the write port should show right now.
   int           m_ptr;
   logic         m_en;
   logic [A-1:0] m_reg;
   logic [W-1:0] m_data;
   int           m_cnt;

   logic [N-1:0] last_ready;
   logic [A-1:0] last_wr_reg;
   logic [15:0]  last_cnt;

   regfile_wb_arb_if #(.WIDTH(W), .DEPTH(D), .NREQ(N)) bus ();

   regfile_wb_arb #(.WIDTH(W), .DEPTH(D), .NREQ(N)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pick(input int p, input logic [N-1:0] v);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rn, input logic hold, input logic [N-1:0] v,
                       input logic [N*A-1:0] r, input logic [N*W-1:0] d);
      int           g;
      logic [N-1:0] exp_rdy;
      logic [A-1:0] tgt;
      @(negedge clk);
      reset_n       = rn;
      bus.wr_hold   = hold;
      bus.req_valid = v;
      bus.req_reg   = r;
      bus.req_data  = d;
      #1;
      g       = pick(m_ptr, v);
      exp_rdy = '0;
      if (rn && !hold && g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", bus.req_ready, exp_rdy);
      check("wr_enable", bus.wr_enable, m_en);
      check("wr_reg",    bus.wr_reg,    m_reg);
      check("wr_data",   bus.wr_data,   m_data);
      check("wr_count",  bus.wr_count,  m_cnt);
      last_ready  = bus.req_ready;
      last_wr_reg = bus.wr_reg;
      last_cnt    = bus.wr_count;
      @(posedge clk);
      if (!rn) begin
         m_ptr = 0; m_en = 1'b0; m_reg = '0; m_data = '0; m_cnt = 0;
      end else begin
         m_en = 1'b0;
         if (exp_rdy != '0) begin
            m_ptr = (g + 1) % N;
            tgt   = r[g*A +: A];
            if (tgt != '0) begin
               m_en   = 1'b1;
               m_reg  = tgt;
               m_data = d[g*W +: W];
               if (m_cnt < 65535) m_cnt++;
            end
         end
      end
   endtask

   logic [N*A-1:0] regs_123;
   logic [N*W-1:0] data_abc;
   logic [N*A-1:0] rr;
   logic [N*W-1:0] rd;
   int             exp_seq [6];

   initial begin
      checks = 0; errors = 0;
      m_ptr = 0; m_en = 1'b0; m_reg = '0; m_data = '0; m_cnt = 0;
      regs_123 = {5'd3, 5'd2, 5'd1};
      data_abc = {32'hCCCC_000C, 32'hBBBB_000B, 32'hAAAA_000A};
      exp_seq  = '{1, 2, 3, 1, 2, 3};

      reset_n = 1'b0; bus.wr_hold = 1'b0; bus.req_valid = '0;
      bus.req_reg = '0; bus.req_data = '0;
      @(posedge clk);
      @(posedge clk);

      // Reset held with everyone valid.
      step(1'b0, 1'b0, 3'b111, regs_123, data_abc);
      step(1'b0, 1'b0, 3'b111, regs_123, data_abc);

      // Round-robin over six cycles, then one idle cycle to see the last write.
      for (int k = 0; k < 7; k++) begin
         if (k < 6) step(1'b1, 1'b0, 3'b111, regs_123, data_abc);
         else       step(1'b1, 1'b0, 3'b000, regs_123, data_abc);
         if (k >= 1) check("rr_seq", last_wr_reg, exp_seq[k-1]);
      end
      check("rr_count", last_cnt, 16'd6);

      // Register 0 from requester 1 is accepted but not written.
      step(1'b1, 1'b0, 3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'hDEAD_BEEF, 32'h0});
      check("reg0_ready", last_ready, 3'b010);
      step(1'b1, 1'b0, 3'b000, regs_123, data_abc);
      check("reg0_count", last_cnt, 16'd6);

      // Hold for three cycles, then resume at the held pointer (requester 2).
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 3'b111, regs_123, data_abc);
      step(1'b1, 1'b0, 3'b111, regs_123, data_abc);
      check("hold_resume", last_ready, 3'b100);

      // Randomized traffic with occasional hold and reset.
      for (int n = 0; n < 400; n++) begin
         rr = (N*A)'($urandom);
         for (int i = 0; i < N; i++) rd[i*W +: W] = $urandom;
         step(($urandom_range(0, 29) != 0), ($urandom_range(0, 4) == 0),
              N'($urandom), rr, rd);
      end

      // Reset mid-stream while requester 2 is granted.
      step(1'b1, 1'b0, 3'b100, regs_123, data_abc);
      step(1'b1, 1'b0, 3'b100, regs_123, data_abc);
      step(1'b0, 1'b0, 3'b100, regs_123, data_abc);
      step(1'b1, 1'b0, 3'b101, regs_123, data_abc);
      check("post_reset_grant", last_ready, 3'b001);
      step(1'b1, 1'b0, 3'b000, regs_123, data_abc);
      check("post_reset_reg", last_wr_reg, 5'd1);

      // Saturation: 65537 writes from a fresh reset.
      step(1'b0, 1'b0, 3'b000, regs_123, data_abc);
      for (int n = 0; n < 65537; n++) begin
         rr = '0;
         rr[A-1:0] = A'($urandom_range(1, D - 1));
         step(1'b1, 1'b0, 3'b001, rr, {64'h0, 32'($urandom)});
      end
      step(1'b1, 1'b0, 3'b000, regs_123, data_abc);
      check("sat_count", last_cnt, 16'hFFFF);
      step(1'b1, 1'b0, 3'b111, regs_123, data_abc);
      step(1'b1, 1'b0, 3'b111, regs_123, data_abc);
      step(1'b1, 1'b0, 3'b000, regs_123, data_abc);
      check("sat_nowrap", last_cnt, 16'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
